// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer around a Fibonacci LFSR: start/seed/len load, valid/ready beat stream, done/lock_err pulses.
// Optional build macro LFSR_ZERO_SEED_FIX_EN replaces a zero seed with all-ones instead of rejecting it.
module lfsr_burst_ctrl #(
   parameter int unsigned      WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
   parameter int unsigned      CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             done,
   output logic             lock_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   localparam logic [WIDTH-1:0] LFSR_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] LFSR_ONES = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   // Feedback bit is the parity of the tapped state bits.
   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   logic [1:0]       state_d,     state_q;
   logic [WIDTH-1:0] lfsr_d,      lfsr_q;
   logic [CNT_W-1:0] rem_d,       rem_q;
   logic             busy_d,      busy_q;
   logic             out_valid_d, out_valid_q;
   logic             done_d,      done_q;
   logic             lock_err_d,  lock_err_q;

   logic [WIDTH-1:0] seed_cap_s;
   logic             seed_reject_s;

   // Seed conditioning at capture time.
   always_comb begin
`ifdef LFSR_ZERO_SEED_FIX_EN
      if (seed == LFSR_ZERO) begin
         seed_cap_s = LFSR_ONES;
      end else begin
         seed_cap_s = seed;
      end
      seed_reject_s = 1'b0;
`else
      seed_cap_s    = seed;
      seed_reject_s = (seed == LFSR_ZERO);
`endif
   end

   // Next-state, LFSR and beat-counter logic; abort wins over a same-cycle handshake.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               lfsr_d = seed_cap_s;
               rem_d  = len;
               if (seed_reject_s) begin
                  state_d = ST_ERR;
               end else if (len == CNT_ZERO) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (out_ready) begin
               lfsr_d = lfsr_next(lfsr_q);
               rem_d  = rem_q - CNT_ONE;
               if (rem_q == CNT_ONE) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output flags are decoded from the next state so they are registered alongside it.
   always_comb begin
      busy_d      = (state_d != ST_IDLE);
      out_valid_d = (state_d == ST_RUN);
      done_d      = (state_d == ST_DONE);
      lock_err_d  = (state_d == ST_ERR);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= LFSR_ZERO;
         rem_q       <= CNT_ZERO;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         lock_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         rem_q       <= rem_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         lock_err_q  <= lock_err_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_data  = lfsr_q;
   assign done      = done_q;
`ifdef LFSR_ZERO_SEED_FIX_EN
   assign lock_err  = 1'b0;
`else
   assign lock_err  = lock_err_q;
`endif

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Self-checking bench for lfsr_burst_ctrl: directed and randomized bursts against a sequence-level model.
// Honours LFSR_ZERO_SEED_FIX_EN for the zero-seed expectations.
module tb_lfsr_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] seed_i = 4'd0;
   logic [7:0] len_i = 8'd0;
   logic       abort = 1'b0;
   logic       out_ready = 1'b0;
   logic       busy, out_valid, done, lock_err;
   logic [3:0] out_data;

   int         vectors = 0;
   int         miscompares = 0;
   logic [15:0] seen = 16'd0;

   lfsr_burst_ctrl #(.WIDTH(4), .TAPS(4'b1100), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed_i), .len(len_i), .abort(abort),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .done(done), .lock_err(lock_err)
   );

   always #5 clk = ~clk;

   // Polynomial x^4+x^3+1 as arithmetic: shift left, append parity of bits 3 and 2.
   function automatic logic [3:0] mstep(input logic [3:0] s);
      int ones;
      int v;
      ones = 0;
      if (s[3]) ones = ones + 1;
      if (s[2]) ones = ones + 1;
      v = (int'(s) * 2) % 16 + (ones % 2);
      return v[3:0];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: always ready, 1: ready every third cycle, 2: random ready.
   task automatic run_burst(input logic [3:0] sd, input int ln, input int mode, input bit mid_start);
      logic [3:0] cur;
      int got;
      int cyc;
      logic rdy;
      cur = sd;
`ifdef LFSR_ZERO_SEED_FIX_EN
      if (sd == 4'd0) cur = 4'hF;
`endif
      chk("pre_busy", busy, 1'b0);
      start = 1'b1; seed_i = sd; len_i = ln[7:0];
      tick;
      start = 1'b0; seed_i = 4'($urandom_range(0, 15));
`ifndef LFSR_ZERO_SEED_FIX_EN
      if (sd == 4'd0) begin
         chk("zs_lock_err", lock_err, 1'b1);
         chk("zs_busy", busy, 1'b1);
         chk("zs_valid", out_valid, 1'b0);
         chk("zs_done", done, 1'b0);
         tick;
         chk("zs_lock_err_end", lock_err, 1'b0);
         chk("zs_busy_end", busy, 1'b0);
         chk("zs_valid_end", out_valid, 1'b0);
         chk("zs_done_end", done, 1'b0);
         return;
      end
`endif
      seen = 16'd0;
      got = 0;
      cyc = 0;
      while (got < ln && cyc < 200) begin
         chk("beat_valid", out_valid, 1'b1);
         chk("beat_data", out_data, cur);
         chk("beat_no_done", done, 1'b0);
         seen[out_data] = 1'b1;
         case (mode)
            0: rdy = 1'b1;
            1: rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         start = mid_start && (cyc == 5);
         seed_i = 4'hA;
         tick;
         start = 1'b0;
         if (rdy) begin
            got = got + 1;
            cur = mstep(cur);
         end
         cyc = cyc + 1;
      end
      chk("beats_count", got, ln);
      chk("done_pulse", done, 1'b1);
      chk("done_valid_low", out_valid, 1'b0);
      chk("done_busy", busy, 1'b1);
      out_ready = 1'b0;
      tick;
      chk("end_done_low", done, 1'b0);
      chk("end_busy_low", busy, 1'b0);
      chk("end_valid_low", out_valid, 1'b0);
      chk("end_state_kept", out_data, cur);
   endtask

   initial begin
      logic [3:0] cur;
      logic [3:0] rs;
      // Reset state.
      rst = 1'b1;
      tick; tick;
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_lock_err", lock_err, 1'b0);
      chk("rst_data", out_data, 4'd0);
      rst = 1'b0;
      tick;

      run_burst(4'b0001, 4, 0, 1'b0);
      run_burst(4'b0001, 4, 1, 1'b0);
      run_burst(4'b0001, 15, 0, 1'b1);
      chk("period_all_seen", seen, 16'hFFFE);
      chk("period_return", out_data, 4'b0001);
      run_burst(4'b0000, 3, 0, 1'b0);
      abort = 1'b1;
      run_burst(4'b0110, 0, 0, 1'b0);
      abort = 1'b0;

      // Abort after two beats with ready high in the abort cycle.
      rs = 4'($urandom_range(1, 15));
      cur = rs;
      start = 1'b1; seed_i = rs; len_i = 8'd8;
      tick;
      start = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk("ab_data", out_data, cur);
         tick;
         cur = mstep(cur);
      end
      abort = 1'b1;
      tick;
      abort = 1'b0;
      out_ready = 1'b0;
      chk("ab_busy", busy, 1'b0);
      chk("ab_valid", out_valid, 1'b0);
      chk("ab_done", done, 1'b0);
      chk("ab_no_step", out_data, cur);
      tick;
      chk("ab_done_later", done, 1'b0);

      // Reset in the middle of a burst.
      start = 1'b1; seed_i = 4'b0101; len_i = 8'd8;
      tick;
      start = 1'b0;
      out_ready = 1'b1;
      tick; tick; tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      out_ready = 1'b0;
      chk("mr_busy", busy, 1'b0);
      chk("mr_valid", out_valid, 1'b0);
      chk("mr_done", done, 1'b0);
      chk("mr_lock_err", lock_err, 1'b0);
      chk("mr_data", out_data, 4'd0);
      tick;
      chk("mr_done_later", done, 1'b0);

      // Randomized bursts, zero seeds and zero lengths included.
      for (int k = 0; k < 12; k++) begin
         run_burst(4'($urandom_range(0, 15)), $urandom_range(0, 10), 2, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
